// File: rtl/scratchpad_arbiter.sv
// Shares a 1R/1W scratchpad between instruction fetch (read-only) and the data port.
// Reads are round-robin arbitrated; writes go straight to the write port.
module scratchpad_arbiter #(
  parameter int BITS         = 32,
  parameter int ADDRESS_BITS = 10
) (
  input  logic                    CLK,
  input  logic                    RSTb,
  input  logic                    i_req,
  input  logic [ADDRESS_BITS-1:0] i_addr,
  output logic                    i_gnt,
  output logic                    i_rvalid,
  output logic [BITS-1:0]         i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDRESS_BITS-1:0] d_addr,
  input  logic [BITS-1:0]         d_wdata,
  input  logic [3:0]              d_wstrb,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [BITS-1:0]         d_rdata,
  output logic [ADDRESS_BITS-1:0] ram_rd_addr,
  output logic [ADDRESS_BITS-1:0] ram_wr_addr,
  output logic [BITS-1:0]         ram_data_in,
  input  logic [BITS-1:0]         ram_data_out,
  output logic                    ram_WRb,
  output logic [3:0]              ram_wstrb
);

  typedef enum logic {RD_I = 1'b0, RD_D = 1'b1} rd_src_e;

  rd_src_e                   last_rd_q, last_rd_d;
  rd_src_e                   resp_sel_q, resp_sel_d;
  logic                      rvld_q, rvld_d;
  logic [ADDRESS_BITS-1:0]   rd_addr_q, rd_addr_d;

  logic wr_gnt, hazard, i_elig, d_elig, i_win, d_win;

  always_comb begin
    // Everything is gated by RSTb so nothing is granted while reset is held.
    wr_gnt = RSTb & d_req & d_we;
    // RAM read of an address being written returns stale data; hold fetch off a cycle.
    hazard = wr_gnt & (i_addr == d_addr);
    i_elig = RSTb & i_req & ~hazard;
    d_elig = RSTb & d_req & ~d_we;
    i_win  = i_elig & (~d_elig | (last_rd_q == RD_D));
    d_win  = d_elig & ~i_win;

    rd_addr_d  = rd_addr_q;
    last_rd_d  = last_rd_q;
    resp_sel_d = resp_sel_q;
    if (i_win) begin
      rd_addr_d  = i_addr;
      last_rd_d  = RD_I;
      resp_sel_d = RD_I;
    end else if (d_win) begin
      rd_addr_d  = d_addr;
      last_rd_d  = RD_D;
      resp_sel_d = RD_D;
    end
    rvld_d = i_win | d_win;

    i_gnt       = i_win;
    d_gnt       = d_win | wr_gnt;
    ram_rd_addr = rd_addr_d;
    ram_wr_addr = d_addr;
    ram_data_in = d_wdata;
    ram_WRb     = ~wr_gnt;
    ram_wstrb   = wr_gnt ? d_wstrb : 4'b0000;

    i_rvalid = rvld_q & (resp_sel_q == RD_I);
    d_rvalid = rvld_q & (resp_sel_q == RD_D);
    i_rdata  = ram_data_out;
    d_rdata  = ram_data_out;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      last_rd_q  <= RD_D;
      resp_sel_q <= RD_I;
      rvld_q     <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      last_rd_q  <= last_rd_d;
      resp_sel_q <= resp_sel_d;
      rvld_q     <= rvld_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_scratchpad_arbiter.sv
// Directed bench for scratchpad_arbiter with a behavioural registered-read scratchpad.
module tb_scratchpad_arbiter;
  localparam int BITS = 32;
  localparam int AW   = 10;

  logic            CLK = 1'b0;
  logic            RSTb;
  logic            i_req, i_gnt, i_rvalid;
  logic [AW-1:0]   i_addr;
  logic [BITS-1:0] i_rdata;
  logic            d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0]   d_addr;
  logic [BITS-1:0] d_wdata, d_rdata;
  logic [3:0]      d_wstrb;
  logic [AW-1:0]   ram_rd_addr, ram_wr_addr;
  logic [BITS-1:0] ram_data_in, ram_data_out;
  logic            ram_WRb;
  logic [3:0]      ram_wstrb;

  logic            pre_we;
  logic [AW-1:0]   pre_addr;
  logic [BITS-1:0] pre_data;
  logic [BITS-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  scratchpad_arbiter #(.BITS(BITS), .ADDRESS_BITS(AW)) dut (
    .CLK(CLK), .RSTb(RSTb),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .ram_WRb(ram_WRb), .ram_wstrb(ram_wstrb)
  );

  // Scratchpad: byte-strobed write, registered read (old data on same-address collision).
  always @(posedge CLK) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!ram_WRb)
      for (int b = 0; b < 4; b++)
        if (ram_wstrb[b]) mem[ram_wr_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
    ram_data_out <= mem[ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [BITS-1:0] v);
    pre_we = 1'b1; pre_addr = a; pre_data = v;
    cyc();
    pre_we = 1'b0;
  endtask

  task automatic idle();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
  endtask

  initial begin
    RSTb = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    idle();
    cyc();
    preload(10'h010, 32'hDEADBEEF);
    preload(10'h004, 32'h04040404);
    preload(10'h008, 32'h08080808);
    preload(10'h020, 32'hAAAAAAAA);
    preload(10'h030, 32'h30303030);
    preload(10'h050, 32'h50505050);

    // Requests held during reset must not be granted.
    i_req = 1'b1; i_addr = 10'h010; d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF;
    #1;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_wrb", ram_WRb, 1);
    chk("rst_wstrb", ram_wstrb, 0);
    chk("rst_i_rvalid", i_rvalid, 0);
    chk("rst_d_rvalid", d_rvalid, 0);
    chk("rst_rd_addr", ram_rd_addr, 0);
    idle();
    cyc();

    // Single fetch in the first cycle out of reset.
    RSTb = 1'b1; i_req = 1'b1; i_addr = 10'h010;
    #1;
    chk("f1_i_gnt", i_gnt, 1);
    chk("f1_d_gnt", d_gnt, 0);
    chk("f1_rd_addr", ram_rd_addr, 10'h010);
    cyc();
    idle();
    chk("f1_i_rvalid", i_rvalid, 1);
    chk("f1_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("f1_d_rvalid", d_rvalid, 0);
    #1;
    chk("f1_hold_addr", ram_rd_addr, 10'h010);
    cyc();
    chk("f1_i_rvalid_off", i_rvalid, 0);

    // Tie after a fresh reset: I, D, I, D.
    RSTb = 1'b0;
    cyc();
    RSTb = 1'b1;
    i_req = 1'b1; i_addr = 10'h004; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h008;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("tie%0d_i_gnt", k), i_gnt, (k % 2 == 0));
      chk($sformatf("tie%0d_d_gnt", k), d_gnt, (k % 2 == 1));
      chk($sformatf("tie%0d_rd_addr", k), ram_rd_addr, (k % 2 == 0) ? 10'h004 : 10'h008);
      cyc();
      chk($sformatf("tie%0d_i_rvalid", k), i_rvalid, (k % 2 == 0));
      chk($sformatf("tie%0d_d_rvalid", k), d_rvalid, (k % 2 == 1));
      chk($sformatf("tie%0d_rdata", k), (k % 2 == 0) ? i_rdata : d_rdata,
          (k % 2 == 0) ? 32'h04040404 : 32'h08080808);
    end
    idle();
    cyc();
    chk("tie_i_rvalid_off", i_rvalid, 0);
    chk("tie_d_rvalid_off", d_rvalid, 0);

    // Byte-strobed write then read back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h020; d_wdata = 32'h11223344; d_wstrb = 4'b0101;
    #1;
    chk("bw_d_gnt", d_gnt, 1);
    chk("bw_wrb", ram_WRb, 0);
    chk("bw_wstrb", ram_wstrb, 4'b0101);
    chk("bw_wr_addr", ram_wr_addr, 10'h020);
    chk("bw_data_in", ram_data_in, 32'h11223344);
    cyc();
    d_we = 1'b0; d_wstrb = 4'h0;
    #1;
    chk("bw_rd_d_gnt", d_gnt, 1);
    chk("bw_rd_wrb", ram_WRb, 1);
    chk("bw_rd_wstrb", ram_wstrb, 0);
    cyc();
    idle();
    chk("bw_d_rvalid", d_rvalid, 1);
    chk("bw_i_rvalid", i_rvalid, 0);
    chk("bw_d_rdata", d_rdata, 32'hAA22AA44);

    // Same-address write and fetch: fetch held one cycle.
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h030; d_wdata = 32'hCAFEF00D; d_wstrb = 4'hF;
    i_req = 1'b1; i_addr = 10'h030;
    #1;
    chk("hz_d_gnt", d_gnt, 1);
    chk("hz_i_gnt", i_gnt, 0);
    cyc();
    d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
    chk("hz_i_rvalid_none", i_rvalid, 0);
    #1;
    chk("hz_i_gnt_retry", i_gnt, 1);
    cyc();
    idle();
    chk("hz_i_rvalid", i_rvalid, 1);
    chk("hz_i_rdata", i_rdata, 32'hCAFEF00D);

    // Write and fetch to different addresses in the same cycle.
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h040; d_wdata = 32'h40404040; d_wstrb = 4'hF;
    i_req = 1'b1; i_addr = 10'h050;
    #1;
    chk("pw_d_gnt", d_gnt, 1);
    chk("pw_i_gnt", i_gnt, 1);
    cyc();
    idle();
    chk("pw_i_rvalid", i_rvalid, 1);
    chk("pw_i_rdata", i_rdata, 32'h50505050);

    // Reset lands between a grant and its response edge.
    i_req = 1'b1; i_addr = 10'h010;
    #1;
    chk("mr_i_gnt", i_gnt, 1);
    #2;
    RSTb = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF;
    #1;
    chk("mr_i_gnt_rst", i_gnt, 0);
    chk("mr_d_gnt_rst", d_gnt, 0);
    chk("mr_wrb_rst", ram_WRb, 1);
    cyc();
    chk("mr_i_rvalid", i_rvalid, 0);
    chk("mr_d_rvalid", d_rvalid, 0);
    RSTb = 1'b1;
    i_req = 1'b1; i_addr = 10'h004; d_req = 1'b1; d_we = 1'b0; d_addr = 10'h008; d_wstrb = 4'h0;
    #1;
    chk("mr_tie_i_gnt", i_gnt, 1);
    chk("mr_tie_d_gnt", d_gnt, 0);
    cyc();
    idle();
    chk("mr_tie_i_rvalid", i_rvalid, 1);
    chk("mr_tie_i_rdata", i_rdata, 32'h04040404);
    chk("mr_tie_d_rvalid", d_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
